// File: rtl/led_bank_driver.sv
// led_bank_driver: NUM_LEDS pins, each FLOAT/PWM/BLINK/BREATHE, reconfigured only at PWM frame boundaries
//   clk, rst                         : clock, synchronous active-high reset
//   cfg_valid/cfg_ready              : single-slot configuration handshake
//   cfg_chan, cfg_mode, cfg_duty     : target channel, mode, duty / blink half-period in frames
//   led, led_oe                      : registered pin levels and output enables (0 = float)
//   frame_tick                       : pulse on the last clk of each PWM frame
module led_bank_driver #(
   parameter int NUM_LEDS = 16,
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 1,
   localparam int CW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic [NUM_LEDS-1:0] led,
   output logic [NUM_LEDS-1:0] led_oe,
   output logic                frame_tick
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   typedef enum logic [1:0] {FLOAT, PWM, BLINK, BREATHE} mode_t;
   logic [PW-1:0] presc;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic tick;
   logic apply;
   logic pend_v;
   logic [CW-1:0] pend_chan;
   mode_t pend_mode;
   logic [PWM_BITS-1:0] pend_duty;
   assign tick = presc == PW'(PRESCALE - 1);
   assign frame_tick = tick && &pwm_cnt;
   assign cfg_ready = !pend_v;
   // pend_v is only set the cycle after an accept, so a tick coinciding with the accept never applies it
   assign apply = pend_v && frame_tick;
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         pwm_cnt <= '0;
         pend_v <= 1'b0;
         pend_chan <= '0;
         pend_mode <= FLOAT;
         pend_duty <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
         if (cfg_valid && cfg_ready) begin
            pend_v <= 1'b1;
            pend_chan <= cfg_chan;
            pend_mode <= mode_t'(cfg_mode);
            pend_duty <= cfg_duty;
         end else if (apply)
            pend_v <= 1'b0;
      end
   end
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      mode_t mode;
      logic [PWM_BITS-1:0] duty;
      logic [PWM_BITS-1:0] bcnt;
      logic [PWM_BITS-1:0] level;
      logic [PWM_BITS-1:0] last;
      logic phase;
      logic dir;
      logic hit;
      logic up;
      logic lv;
      logic led_q;
      logic oe_q;
      // out-of-range channels never match, so such a request is dropped on apply
      assign hit = apply && pend_chan == CW'(i);
      assign last = duty == '0 ? '0 : duty - 1'b1;
      // triangle wave: reverse at the rails instead of wrapping
      assign up = dir ? level == '0 : level != '1;
      assign lv = mode == PWM ? pwm_cnt < duty : mode == BLINK ? phase : mode == BREATHE ? pwm_cnt < level : 1'b0;
      assign led[i] = led_q;
      assign led_oe[i] = oe_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            mode <= FLOAT;
            duty <= '0;
            bcnt <= '0;
            level <= '0;
            phase <= 1'b0;
            dir <= 1'b0;
            led_q <= 1'b0;
            oe_q <= 1'b0;
         end else begin
            led_q <= lv;
            oe_q <= mode != FLOAT;
            if (hit) begin
               mode <= pend_mode;
               duty <= pend_duty;
               bcnt <= '0;
               level <= '0;
               phase <= 1'b0;
               dir <= 1'b0;
            end else if (frame_tick && mode == BLINK) begin
               bcnt <= bcnt == last ? '0 : bcnt + 1'b1;
               if (bcnt == last)
                  phase <= !phase;
            end else if (frame_tick && mode == BREATHE) begin
               level <= up ? level + 1'b1 : level - 1'b1;
               dir <= !up;
            end
         end
      end
   end
endmodule

// File: tb/tb_led_bank_driver.sv
// tb_led_bank_driver: randomized and directed checks of led_bank_driver against a frame-arithmetic model
module tb_led_bank_driver;
   localparam int N = 16;
   localparam int B = 4;
   localparam int P = 2;
   localparam int FR = P << B;
   localparam int MX = (1 << B) - 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_valid = 1'b0;
   logic cfg_ready;
   logic [3:0] cfg_chan = '0;
   logic [1:0] cfg_mode = '0;
   logic [B-1:0] cfg_duty = '0;
   logic [N-1:0] led;
   logic [N-1:0] led_oe;
   logic frame_tick;
   led_bank_driver #(.NUM_LEDS(N), .PWM_BITS(B), .PRESCALE(P)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
      .led(led), .led_oe(led_oe), .frame_tick(frame_tick)
   );
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   int d;
   int m_mode [N];
   int m_duty [N];
   int m_f0 [N];
   bit pend;
   int pend_t, pc, pm, pdu;
   int acc_d, commit_d, first_ft;
   logic [N-1:0] exp_led, exp_oe, sl;
   bit dv;
   int dc, dm, dd;
   bit accepted;
   function automatic int tri_level(int k);
      int r = k % (2 * MX);
      return r <= MX ? r : 2 * MX - r;
   endfunction
   // pin level during cycle e: k frames have elapsed since the channel's config took effect
   function automatic bit model_led(int ch, int e);
      int p = (e / P) % (1 << B);
      int k = e / FR - m_f0[ch];
      case (m_mode[ch])
         1: return p < m_duty[ch];
         2: return ((k / (m_duty[ch] == 0 ? 1 : m_duty[ch])) % 2) == 1;
         3: return p < tri_level(k);
         default: return 1'b0;
      endcase
   endfunction
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s d=%0d observed=%0h expected=%0h", tag, d, obs, expv);
      end
   endtask
   task automatic step();
      @(negedge clk);
      rst = 1'b0;
      if (pend && d == pend_t + 1) begin
         m_mode[pc] = pm;
         m_duty[pc] = pdu;
         m_f0[pc] = d / FR;
         pend = 1'b0;
         commit_d = d;
      end
      chk("frame_tick", 64'(frame_tick), 64'(d % FR == FR - 1));
      chk("cfg_ready", 64'(cfg_ready), 64'(!pend));
      chk("led", 64'(led), 64'(exp_led));
      chk("led_oe", 64'(led_oe), 64'(exp_oe));
      sl = led;
      if (frame_tick && first_ft < 0)
         first_ft = d;
      cfg_valid = dv;
      cfg_chan = 4'(dc);
      cfg_mode = 2'(dm);
      cfg_duty = B'(dd);
      if (dv && !pend) begin
         pend = 1'b1;
         pc = dc;
         pm = dm;
         pdu = dd;
         pend_t = (d / FR) * FR + FR - 1;
         if (pend_t == d)
            pend_t += FR;
         accepted = 1'b1;
         acc_d = d;
      end
      for (int i = 0; i < N; i++) begin
         exp_led[i] = model_led(i, d);
         exp_oe[i] = m_mode[i] != 0;
      end
      @(posedge clk);
      d++;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      dv = 1'b0;
      cfg_valid = 1'b0;
      repeat (3) @(posedge clk);
      d = 0;
      pend = 1'b0;
      exp_led = '0;
      exp_oe = '0;
      first_ft = -1;
      for (int i = 0; i < N; i++) begin
         m_mode[i] = 0;
         m_duty[i] = 0;
         m_f0[i] = 0;
      end
   endtask
   task automatic send(int c, int m, int du);
      int n = 0;
      dv = 1'b1;
      dc = c;
      dm = m;
      dd = du;
      accepted = 1'b0;
      while (!accepted && n < 100) begin
         step();
         n++;
      end
      dv = 1'b0;
      chk("accept_timeout", 64'(accepted), 64'd1);
   endtask
   task automatic settle();
      int n = 0;
      while (pend && n < 100) begin
         step();
         n++;
      end
      chk("apply_timeout", 64'(pend), 64'd0);
   endtask
   task automatic wait_phase(int p);
      while (d % FR != p)
         step();
   endtask
   initial begin
      int cnt;
      dv = 1'b0;
      dc = 0;
      dm = 0;
      dd = 0;
      do_reset();
      repeat (70) step();
      chk("first_frame_tick", 64'(first_ft), 64'(FR - 1));
      send(3, 1, 4);
      settle();
      cnt = 0;
      repeat (FR) begin
         step();
         cnt += int'(sl[3]);
      end
      chk("pwm_high_clk", 64'(cnt), 64'd8);
      chk("others_float", 64'(led_oe), 64'h0008);
      send(0, 2, 3);
      settle();
      repeat (8 * FR) step();
      send(7, 2, 0);
      settle();
      repeat (3 * FR) step();
      send(15, 3, int'($urandom_range(0, MX)));
      settle();
      for (int fr = 0; fr < 2 * MX + 2; fr++) begin
         cnt = 0;
         repeat (FR) begin
            step();
            cnt += int'(sl[15]);
         end
         chk("breathe_high_clk", 64'(cnt), 64'(P * tri_level(fr)));
      end
      wait_phase(FR - 1);
      send(9, 1, 7);
      settle();
      chk("coincident_apply_delay", 64'(commit_d - acc_d), 64'(FR + 1));
      wait_phase(2);
      send(10, 1, 9);
      dv = 1'b1;
      dc = 11;
      dm = 2;
      dd = 1;
      repeat (5) step();
      dv = 1'b0;
      settle();
      repeat (FR) step();
      chk("ignored_while_pending", 64'(led_oe[11]), 64'd0);
      repeat (20) begin
         repeat ($urandom_range(0, 40)) step();
         send(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, MX)));
      end
      settle();
      repeat (2 * FR) step();
      wait_phase(3);
      send(5, 1, 8);
      repeat (4) step();
      do_reset();
      step();
      chk("rst_chan5_float", 64'(led_oe[5]), 64'd0);
      chk("rst_ready", 64'(cfg_ready), 64'd1);
      repeat (3 * FR) step();
      chk("rst_chan5_still_float", 64'(led_oe[5]), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
